// File: rtl/platform_pkg.sv
// Shared constants and types for the platform position sequencer.
// Holds the reset layout, FSM encoding and LFSR parameters.
package platform_pkg;

    localparam int NUM_PLAT = 8;

    localparam logic [9:0] LAYOUT_X [NUM_PLAT] = '{
        10'd140, 10'd180, 10'd220, 10'd260, 10'd300, 10'd340, 10'd380, 10'd420
    };

    localparam logic [9:0] LAYOUT_Y [NUM_PLAT] = '{
        10'd40, 10'd96, 10'd152, 10'd208, 10'd264, 10'd320, 10'd376, 10'd432
    };

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } sched_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback bits 15/13/12/10, i.e. polynomial x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, shifting left with feedback into bit 0.
// A nonzero seed keeps it off the all-zero lock-up state.
module lfsr16
    import platform_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/platform_scheduler.sv
// Per-frame sweep of the 8-entry platform table: scroll down, recycle off-screen slots.
// Optional horizontal drift of odd slots is enabled with `define PLATFORM_DRIFT_EN.
module platform_scheduler
    import platform_pkg::*;
#(
    parameter int         W          = 640,
    parameter int         H          = 480,
    parameter int         X_Min      = 140,
    parameter int         X_Max      = 499,
    parameter int         PLAT_W     = 40,
    parameter logic [7:0] PLAY_STATE = 8'd1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [7:0]  state,
    input  logic        scroll_valid,
    input  logic [5:0]  scroll_amt,
    output logic [9:0]  Platform_X_out [0:NUM_PLAT-1],
    output logic [9:0]  Platform_Y_out [0:NUM_PLAT-1],
    output logic        busy,
    output logic        frame_done,
    output logic [3:0]  recycled,
    output logic        overrun
);

    // Rightmost legal left edge; the playfield is also clipped to the screen.
    localparam int X_RIGHT = ((X_Max < W) ? X_Max : (W - 1)) - PLAT_W + 1;
    localparam int R       = X_RIGHT - X_Min;

    logic [15:0] lfsr;
    logic        unused_lfsr_hi;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (Clk),
        .rst (Reset),
        .q   (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:9];

    sched_state_t fsm_q, fsm_d;
    logic [2:0]   sync_q, sync_d;
    logic [9:0]   x_q [NUM_PLAT];
    logic [9:0]   x_d [NUM_PLAT];
    logic [9:0]   y_q [NUM_PLAT];
    logic [9:0]   y_d [NUM_PLAT];
    logic [2:0]   idx_q, idx_d;
    logic [5:0]   amt_q, amt_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         busy_q, busy_d;
    logic         frame_done_q, frame_done_d;
    logic [3:0]   recycled_q, recycled_d;
    logic         overrun_q, overrun_d;
`ifdef PLATFORM_DRIFT_EN
    logic [NUM_PLAT-1:0] dir_q, dir_d;
`endif

    logic        tick;
    logic [8:0]  v;
    logic [9:0]  off;
    logic [10:0] y_n;
    logic [10:0] y_wrap;
    logic        wrap;

    // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the previous sample.
    assign tick   = sync_q[1] & ~sync_q[2];
    assign v      = lfsr[8:0];
    assign off    = (v > 9'(R)) ? (10'(v) - 10'(R)) : 10'(v);
    assign y_n    = {1'b0, y_q[idx_q]} + 11'(amt_q);
    assign y_wrap = y_n - 11'(H);
    assign wrap   = (y_n > 11'(H - 1));

    always_comb begin
        sync_d       = {sync_q[1:0], frame_clk};
        fsm_d        = fsm_q;
        x_d          = x_q;
        y_d          = y_q;
        idx_d        = idx_q;
        amt_d        = amt_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        recycled_d   = recycled_q;
        // A frame edge landing anywhere outside IDLE is dropped and flagged.
        overrun_d    = overrun_q | (tick && (fsm_q != IDLE));
`ifdef PLATFORM_DRIFT_EN
        dir_d        = dir_q;
`endif

        case (fsm_q)
            IDLE: begin
                if (tick && (state == PLAY_STATE)) begin
                    amt_d  = scroll_valid ? scroll_amt : 6'd0;
                    cnt_d  = 4'd0;
                    idx_d  = 3'd0;
                    busy_d = 1'b1;
                    fsm_d  = SWEEP;
                end else if (tick && (state == 8'd0)) begin
                    x_d = LAYOUT_X;
                    y_d = LAYOUT_Y;
`ifdef PLATFORM_DRIFT_EN
                    dir_d = '1;
`endif
                end
            end

            SWEEP: begin
                if (wrap) begin
                    y_d[idx_q] = y_wrap[9:0];
                    x_d[idx_q] = 10'(X_Min) + off;
                    cnt_d      = cnt_q + 4'd1;
`ifdef PLATFORM_DRIFT_EN
                    dir_d[idx_q] = 1'b1;
`endif
                end else begin
                    y_d[idx_q] = y_n[9:0];
`ifdef PLATFORM_DRIFT_EN
                    // Hitting an edge reverses direction; X holds for that sweep.
                    if (idx_q[0]) begin
                        if (dir_q[idx_q]) begin
                            if (x_q[idx_q] >= 10'(X_RIGHT)) begin
                                dir_d[idx_q] = 1'b0;
                            end else begin
                                x_d[idx_q] = x_q[idx_q] + 10'd1;
                            end
                        end else begin
                            if (x_q[idx_q] <= 10'(X_Min)) begin
                                dir_d[idx_q] = 1'b1;
                            end else begin
                                x_d[idx_q] = x_q[idx_q] - 10'd1;
                            end
                        end
                    end
`endif
                end

                if (idx_q == 3'(NUM_PLAT - 1)) begin
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                    recycled_d   = cnt_d;
                    fsm_d        = DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end

            DONE: begin
                fsm_d = IDLE;
            end

            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fsm_q        <= IDLE;
            sync_q       <= 3'b000;
            x_q          <= LAYOUT_X;
            y_q          <= LAYOUT_Y;
            idx_q        <= 3'd0;
            amt_q        <= 6'd0;
            cnt_q        <= 4'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            recycled_q   <= 4'd0;
            overrun_q    <= 1'b0;
`ifdef PLATFORM_DRIFT_EN
            dir_q        <= '1;
`endif
        end else begin
            fsm_q        <= fsm_d;
            sync_q       <= sync_d;
            x_q          <= x_d;
            y_q          <= y_d;
            idx_q        <= idx_d;
            amt_q        <= amt_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            recycled_q   <= recycled_d;
            overrun_q    <= overrun_d;
`ifdef PLATFORM_DRIFT_EN
            dir_q        <= dir_d;
`endif
        end
    end

    assign Platform_X_out = x_q;
    assign Platform_Y_out = y_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign recycled       = recycled_q;
    assign overrun        = overrun_q;

endmodule
